frame_capture_ctrl: RTL and testbench
=====================================

Name: frame_capture_ctrl

Overview:
Sequences the frame RAM. It captures one camera frame byte-by-byte into the RAM on request. Once the frame is complete, it serves pipelined pixel reads to the colour-classification logic. It is the only master of the RAM's we/data/addr_line/addr_column inputs.

Parameters:
LINES, 176, frame height in lines
COLUMNS, 288, bytes per line
S_DATA, 8, byte width
S_LINE, 8, line address width
S_COLUMN, 9, column address width

Ports:
clk  in  1  system clock; all logic on rising edge
clear  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; arms capture of the next frame
cam_vsync  in  1  frame marker, already in clk domain; high between frames
cam_href  in  1  line-valid, already in clk domain
cam_valid  in  1  one-cycle byte strobe, already in clk domain
cam_data  in  S_DATA  camera byte
ram_we  out  1  RAM write enable
ram_data  out  S_DATA  RAM write data
ram_line  out  S_LINE  RAM line address
ram_column  out  S_COLUMN  RAM column address
ram_q  in  S_DATA  RAM read data
rd_req  in  1  read request; valid only when frame_ready=1
rd_line  in  S_LINE  read line
rd_column  in  S_COLUMN  read column
rd_valid  out  1  read data valid
rd_data  out  S_DATA  read data
busy  out  1  high from the accepted start until capture ends
frame_ready  out  1  high while a complete frame can be read
err  out  1  sticky capture error; cleared on the next accepted start

Behaviour:
- Reset: clear=1 at a clock edge forces state IDLE. All outputs go to 0, and line/column counters go to 0. The RAM contents are not touched. clear overrides every other input, including mid-capture.
- RAM protocol:
  - The RAM latches the address on any edge where ram_we=0.
  - When ram_we=1, it writes to the previously latched address.
  - q reflects the latched address combinationally.
  - Every write is therefore two cycles: ADDR (we=0, address driven) then WR (we=1, address held, data driven).
- State IDLE: start=1 -> ARM, busy=1, err=0, frame_ready=0.
- State ARM: wait for a cam_vsync rising edge. The edge detector is a 1-flop delay of cam_vsync, reset to 0. On the edge -> VSYNC.
- State VSYNC: cam_vsync=0 -> CAP. Counters are zeroed on entry.
- State CAP:
  - cam_valid & cam_href: the byte is latched into ram_data and the sub-phase sequence ADDR then WR runs.
    - Write address = (line, col).
    - col increments after WR.
    - Write latency is 2 cycles from the strobe.
  - cam_valid during ADDR or WR (spacing <2 cycles): the byte is dropped and err=1.
  - cam_valid with cam_href=0: ignored.
  - col already equal to COLUMNS: the byte is dropped, no RAM access, err=1.
  - line >= LINES: the byte is dropped, err=1.
  - cam_href falling edge: if col!=0 then line++. If col!=COLUMNS, err=1. Then col=0.
  - cam_vsync rising edge: after any pending WR finishes -> READY. busy=0 and frame_ready=1. If line!=LINES, err=1.
- State READY:
  - Read pipeline:
    - rd_req=1: ram_line/ram_column are driven combinationally from rd_line/rd_column with ram_we=0.
    - On the next cycle, rd_valid=1 and rd_data=ram_q (registered capture of q). Latency is 1 cycle.
    - Throughput is one read per cycle; back-to-back requests give back-to-back rd_valid.
  - Out-of-range address (line>=LINES or column>=COLUMNS): no RAM access. rd_valid=1 on the next cycle with rd_data=0.
  - start=1: -> ARM, frame_ready=0, err=0. A rd_req in the same cycle is ignored, and no rd_valid follows.
- rd_req outside READY: ignored; rd_valid stays 0.
- start outside IDLE/READY: ignored.
- Outside CAP WR, ram_we=0.

Test Plan:
- Reset mid-capture: clear=1 during CAP -> next cycle state IDLE; busy, ram_we, frame_ready and err all 0; no further RAM writes.
- Nominal 2x3 frame (LINES=2, COLUMNS=3): start, vsync pulse, 2 lines of 3 bytes spaced 2 cycles (0x10..0x15), vsync rise.
  - Writes occur at (0,0..2) and (1,0..2) with each ADDR cycle preceding its WR.
  - Then frame_ready=1, busy=0, err=0.
- Readback on the 2x3 frame: rd_req on consecutive cycles for (0,0), (1,2), (0,1) -> rd_valid on 3 consecutive cycles with data 0x10, 0x15, 0x11. Out-of-range (2,0) -> rd_valid=1, rd_data=0.
- Too-fast strobes: cam_valid on consecutive cycles -> second byte not written; err=1 persists through READY.
- Long line: 4 bytes into a COLUMNS=3 line -> 4th byte dropped, err=1, next line writes at column 0.
- Re-arm with a simultaneous read: start and rd_req in the same READY cycle -> no rd_valid; state ARM, frame_ready=0, err=0.

Source files
------------

// File: rtl/frame_capture_ctrl_if.sv
// Camera input, frame RAM bus and pixel-read signals of the frame capture controller.
// slave is the controller's view; master is the view of the logic around it.
interface frame_capture_ctrl_if #(
  parameter int S_DATA   = 8,
  parameter int S_LINE   = 8,
  parameter int S_COLUMN = 9
);
  logic                start;
  logic                cam_vsync;
  logic                cam_href;
  logic                cam_valid;
  logic [S_DATA-1:0]   cam_data;
  logic                ram_we;
  logic [S_DATA-1:0]   ram_data;
  logic [S_LINE-1:0]   ram_line;
  logic [S_COLUMN-1:0] ram_column;
  logic [S_DATA-1:0]   ram_q;
  logic                rd_req;
  logic [S_LINE-1:0]   rd_line;
  logic [S_COLUMN-1:0] rd_column;
  logic                rd_valid;
  logic [S_DATA-1:0]   rd_data;
  logic                busy;
  logic                frame_ready;
  logic                err;

  modport slave (
    input  start, cam_vsync, cam_href, cam_valid, cam_data, ram_q,
           rd_req, rd_line, rd_column,
    output ram_we, ram_data, ram_line, ram_column, rd_valid, rd_data,
           busy, frame_ready, err
  );

  modport master (
    output start, cam_vsync, cam_href, cam_valid, cam_data, ram_q,
           rd_req, rd_line, rd_column,
    input  ram_we, ram_data, ram_line, ram_column, rd_valid, rd_data,
           busy, frame_ready, err
  );
endinterface

// File: rtl/frame_capture_ctrl.sv
// Frame RAM sequencer: captures one camera frame as two-cycle RAM writes (address, then
// write strobe), then serves one-cycle-latency pixel reads until re-armed.
//
// state  | meaning
// IDLE   | after clear; waits for start
// ARM    | capture armed; waits for a cam_vsync rising edge
// VSYNC  | inside the vsync pulse; counters zeroed; waits for cam_vsync low
// CAP    | capturing bytes; ends on the next cam_vsync rising edge
// READY  | frame complete; serves pixel reads
module frame_capture_ctrl #(
  parameter int LINES    = 176,
  parameter int COLUMNS  = 288,
  parameter int S_DATA   = 8,
  parameter int S_LINE   = 8,
  parameter int S_COLUMN = 9
) (
  input logic               clk,
  input logic               clear,
  frame_capture_ctrl_if.slave bus
);

  localparam logic [S_LINE-1:0]   LINES_C = S_LINE'(LINES);
  localparam logic [S_COLUMN-1:0] COLS_C  = S_COLUMN'(COLUMNS);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_VSYNC, S_CAP, S_READY} state_e;
  typedef enum logic [1:0] {PH_NONE, PH_ADDR, PH_WR} phase_e;

  state_e              state_q, state_d;
  phase_e              phase_q, phase_d;
  logic [S_LINE-1:0]   line_q, line_d;
  logic [S_COLUMN-1:0] col_q, col_d;
  logic                vsync_q, vsync_d;
  logic                href_q, href_d;
  logic                done_pend_q, done_pend_d;
  logic                busy_q, busy_d;
  logic                frame_ready_q, frame_ready_d;
  logic                err_q, err_d;
  logic                rd_valid_q, rd_valid_d;
  logic [S_DATA-1:0]   rd_data_q, rd_data_d;
  logic                ram_we_q, ram_we_d;
  logic [S_DATA-1:0]   ram_data_q, ram_data_d;
  logic [S_LINE-1:0]   ram_line_q, ram_line_d;
  logic [S_COLUMN-1:0] ram_column_q, ram_column_d;

  logic vsync_rise, href_fall, strobe, done_req, rd_in_range, rd_hit;

  always_comb begin
    vsync_rise  = bus.cam_vsync & ~vsync_q;
    href_fall   = href_q & ~bus.cam_href;
    strobe      = bus.cam_valid & bus.cam_href;
    done_req    = vsync_rise | done_pend_q;
    rd_in_range = (bus.rd_line < LINES_C) && (bus.rd_column < COLS_C);
    rd_hit      = (state_q == S_READY) && bus.rd_req && !bus.start && rd_in_range;

    state_d       = state_q;
    phase_d       = phase_q;
    line_d        = line_q;
    col_d         = col_q;
    vsync_d       = bus.cam_vsync;
    href_d        = bus.cam_href;
    done_pend_d   = done_pend_q;
    busy_d        = busy_q;
    frame_ready_d = frame_ready_q;
    err_d         = err_q;
    rd_valid_d    = 1'b0;
    rd_data_d     = '0;
    ram_we_d      = 1'b0;
    ram_data_d    = ram_data_q;
    ram_line_d    = ram_line_q;
    ram_column_d  = ram_column_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d       = S_ARM;
          busy_d        = 1'b1;
          err_d         = 1'b0;
          frame_ready_d = 1'b0;
        end
      end

      S_ARM: begin
        if (vsync_rise) begin
          state_d     = S_VSYNC;
          line_d      = '0;
          col_d       = '0;
          phase_d     = PH_NONE;
          done_pend_d = 1'b0;
        end
      end

      S_VSYNC: begin
        if (!bus.cam_vsync) state_d = S_CAP;
      end

      S_CAP: begin
        // The column counter advances when a byte is accepted, so it always counts
        // bytes committed to the current line even while the write is in flight.
        if (phase_q == PH_ADDR) begin
          phase_d  = PH_WR;
          ram_we_d = 1'b1;
        end else begin
          phase_d = PH_NONE;
        end

        if (done_req) begin
          if (phase_q == PH_ADDR) begin
            done_pend_d = 1'b1;
          end else begin
            state_d       = S_READY;
            done_pend_d   = 1'b0;
            busy_d        = 1'b0;
            frame_ready_d = 1'b1;
            if (line_q != LINES_C) err_d = 1'b1;
          end
        end else if (href_fall) begin
          if (col_q != '0) line_d = line_q + 1'b1;
          if (col_q != COLS_C) err_d = 1'b1;
          col_d = '0;
        end else if (strobe) begin
          if (phase_q == PH_ADDR || col_q == COLS_C || line_q >= LINES_C) begin
            err_d = 1'b1;
          end else begin
            ram_data_d   = bus.cam_data;
            ram_line_d   = line_q;
            ram_column_d = col_q;
            col_d        = col_q + 1'b1;
            phase_d      = PH_ADDR;
          end
        end
      end

      S_READY: begin
        if (bus.start) begin
          state_d       = S_ARM;
          busy_d        = 1'b1;
          err_d         = 1'b0;
          frame_ready_d = 1'b0;
        end else if (bus.rd_req) begin
          rd_valid_d = 1'b1;
          rd_data_d  = rd_in_range ? bus.ram_q : '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q       <= S_IDLE;
      phase_q       <= PH_NONE;
      line_q        <= '0;
      col_q         <= '0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      done_pend_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_ready_q <= 1'b0;
      err_q         <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      ram_we_q      <= 1'b0;
      ram_data_q    <= '0;
      ram_line_q    <= '0;
      ram_column_q  <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      line_q        <= line_d;
      col_q         <= col_d;
      vsync_q       <= vsync_d;
      href_q        <= href_d;
      done_pend_q   <= done_pend_d;
      busy_q        <= busy_d;
      frame_ready_q <= frame_ready_d;
      err_q         <= err_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      ram_we_q      <= ram_we_d;
      ram_data_q    <= ram_data_d;
      ram_line_q    <= ram_line_d;
      ram_column_q  <= ram_column_d;
    end
  end

  // Read addresses bypass the registers so the RAM output is ready at the next edge.
  assign bus.ram_line    = rd_hit ? bus.rd_line : ram_line_q;
  assign bus.ram_column  = rd_hit ? bus.rd_column : ram_column_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_data    = ram_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.busy        = busy_q;
  assign bus.frame_ready = frame_ready_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl on a 2x3 frame with a behavioural frame RAM.
module tb_frame_capture_ctrl;
  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  frame_capture_ctrl_if bus_if ();

  frame_capture_ctrl #(.LINES(2), .COLUMNS(3)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus_if)
  );

  // Frame RAM: address latched on edges with we=0, write to the latched address when we=1.
  logic [7:0] mem [0:255];
  logic [7:0] lat_idx = 8'd0;
  logic [7:0] wr_addr [0:31];
  logic [7:0] wr_dat  [0:31];
  int wr_cnt = 0;
  int hold_err = 0;

  assign bus_if.ram_q = mem[{bus_if.ram_line[3:0], bus_if.ram_column[3:0]}];

  always @(posedge clk) begin
    if (bus_if.ram_we) begin
      mem[lat_idx] <= bus_if.ram_data;
      wr_addr[wr_cnt[4:0]] <= lat_idx;
      wr_dat[wr_cnt[4:0]]  <= bus_if.ram_data;
      wr_cnt <= wr_cnt + 1;
      if ({bus_if.ram_line[3:0], bus_if.ram_column[3:0]} != lat_idx) hold_err <= hold_err + 1;
    end else begin
      lat_idx <= {bus_if.ram_line[3:0], bus_if.ram_column[3:0]};
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic vsync_pulse();
    bus_if.cam_vsync = 1'b0; cyc();
    bus_if.cam_vsync = 1'b1; cyc();
    bus_if.cam_vsync = 1'b0; cyc();
  endtask

  task automatic send_line(input int n, input logic [7:0] base);
    bus_if.cam_href = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus_if.cam_valid = 1'b1;
      bus_if.cam_data  = base + 8'(i);
      cyc();
      bus_if.cam_valid = 1'b0;
      cyc();
    end
    bus_if.cam_href = 1'b0;
    cyc(); cyc();
  endtask

  task automatic read_px(input logic [7:0] line, input logic [8:0] col,
                         input logic [7:0] exp, input string tag);
    bus_if.rd_req = 1'b1; bus_if.rd_line = line; bus_if.rd_column = col;
    cyc();
    bus_if.rd_req = 1'b0;
    chk({tag, "_valid"}, 32'(bus_if.rd_valid), 32'd1);
    chk({tag, "_data"}, 32'(bus_if.rd_data), 32'(exp));
  endtask

  logic [7:0] exp_addr [0:5];
  logic [7:0] exp_dat  [0:5];

  initial begin
    exp_addr[0] = 8'h00; exp_addr[1] = 8'h01; exp_addr[2] = 8'h02;
    exp_addr[3] = 8'h10; exp_addr[4] = 8'h11; exp_addr[5] = 8'h12;
    for (int i = 0; i < 6; i++) exp_dat[i] = 8'h10 + 8'(i);

    clear = 1'b1;
    bus_if.start = 1'b0; bus_if.cam_vsync = 1'b1; bus_if.cam_href = 1'b0;
    bus_if.cam_valid = 1'b0; bus_if.cam_data = 8'h00;
    bus_if.rd_req = 1'b0; bus_if.rd_line = 8'd0; bus_if.rd_column = 9'd0;
    cyc(); cyc();
    clear = 1'b0;
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_ready", 32'(bus_if.frame_ready), 32'd0);
    chk("rst_err", 32'(bus_if.err), 32'd0);
    chk("rst_we", 32'(bus_if.ram_we), 32'd0);
    chk("rst_rd_valid", 32'(bus_if.rd_valid), 32'd0);

    // Read request before any frame must be ignored
    bus_if.rd_req = 1'b1; cyc(); bus_if.rd_req = 1'b0;
    chk("idle_rd_ignored", 32'(bus_if.rd_valid), 32'd0);

    // Frame A: nominal 2x3 capture
    bus_if.start = 1'b1; cyc(); bus_if.start = 1'b0;
    chk("a_busy", 32'(bus_if.busy), 32'd1);
    vsync_pulse();
    send_line(3, 8'h10);
    send_line(3, 8'h13);
    chk("a_busy_cap", 32'(bus_if.busy), 32'd1);
    chk("a_ready_cap", 32'(bus_if.frame_ready), 32'd0);
    bus_if.cam_vsync = 1'b1; cyc();
    chk("a_ready", 32'(bus_if.frame_ready), 32'd1);
    chk("a_busy_end", 32'(bus_if.busy), 32'd0);
    chk("a_err", 32'(bus_if.err), 32'd0);
    chk("a_wr_cnt", 32'(wr_cnt), 32'd6);
    chk("a_hold", 32'(hold_err), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("a_wr%0d_addr", i), 32'(wr_addr[i]), 32'(exp_addr[i]));
      chk($sformatf("a_wr%0d_data", i), 32'(wr_dat[i]), 32'(exp_dat[i]));
    end

    // Back-to-back reads, then out of range
    bus_if.rd_req = 1'b1; bus_if.rd_line = 8'd0; bus_if.rd_column = 9'd0;
    cyc();
    chk("rd0_valid", 32'(bus_if.rd_valid), 32'd1);
    chk("rd0_data", 32'(bus_if.rd_data), 32'h10);
    bus_if.rd_line = 8'd1; bus_if.rd_column = 9'd2;
    #1;
    chk("rd1_ram_line", 32'(bus_if.ram_line), 32'd1);
    chk("rd1_ram_col", 32'(bus_if.ram_column), 32'd2);
    chk("rd1_ram_we", 32'(bus_if.ram_we), 32'd0);
    cyc();
    chk("rd1_valid", 32'(bus_if.rd_valid), 32'd1);
    chk("rd1_data", 32'(bus_if.rd_data), 32'h15);
    bus_if.rd_line = 8'd0; bus_if.rd_column = 9'd1;
    cyc();
    chk("rd2_valid", 32'(bus_if.rd_valid), 32'd1);
    chk("rd2_data", 32'(bus_if.rd_data), 32'h11);
    bus_if.rd_line = 8'd2; bus_if.rd_column = 9'd0;
    cyc();
    chk("rd_oor_valid", 32'(bus_if.rd_valid), 32'd1);
    chk("rd_oor_data", 32'(bus_if.rd_data), 32'h00);
    bus_if.rd_req = 1'b0;
    cyc();
    chk("rd_idle_valid", 32'(bus_if.rd_valid), 32'd0);

    // Re-arm with a simultaneous read
    bus_if.start = 1'b1; bus_if.rd_req = 1'b1; bus_if.rd_line = 8'd0; bus_if.rd_column = 9'd0;
    cyc();
    bus_if.start = 1'b0; bus_if.rd_req = 1'b0;
    chk("rearm_rd_valid", 32'(bus_if.rd_valid), 32'd0);
    chk("rearm_ready", 32'(bus_if.frame_ready), 32'd0);
    chk("rearm_err", 32'(bus_if.err), 32'd0);
    chk("rearm_busy", 32'(bus_if.busy), 32'd1);

    // Frame B: consecutive strobes on line 0, second byte dropped
    vsync_pulse();
    bus_if.cam_href = 1'b1;
    bus_if.cam_valid = 1'b1; bus_if.cam_data = 8'h20; cyc();
    bus_if.cam_data = 8'h21; cyc();
    bus_if.cam_valid = 1'b0; cyc();
    chk("fast_err", 32'(bus_if.err), 32'd1);
    bus_if.cam_valid = 1'b1; bus_if.cam_data = 8'h22; cyc();
    bus_if.cam_valid = 1'b0; cyc();
    bus_if.cam_valid = 1'b1; bus_if.cam_data = 8'h23; cyc();
    bus_if.cam_valid = 1'b0; cyc();
    bus_if.cam_href = 1'b0; cyc(); cyc();
    send_line(3, 8'h24);
    bus_if.cam_vsync = 1'b1; cyc();
    chk("b_ready", 32'(bus_if.frame_ready), 32'd1);
    chk("b_err_persist", 32'(bus_if.err), 32'd1);
    chk("b_wr_cnt", 32'(wr_cnt), 32'd12);
    read_px(8'd0, 9'd1, 8'h22, "b_px01");
    read_px(8'd0, 9'd2, 8'h23, "b_px02");
    read_px(8'd1, 9'd0, 8'h24, "b_px10");

    // Frame C: 4 bytes into a 3-column line
    bus_if.start = 1'b1; cyc(); bus_if.start = 1'b0;
    chk("c_err_cleared", 32'(bus_if.err), 32'd0);
    vsync_pulse();
    send_line(4, 8'h30);
    chk("c_long_err", 32'(bus_if.err), 32'd1);
    send_line(3, 8'h34);
    bus_if.cam_vsync = 1'b1; cyc();
    chk("c_ready", 32'(bus_if.frame_ready), 32'd1);
    chk("c_wr_cnt", 32'(wr_cnt), 32'd18);
    read_px(8'd0, 9'd2, 8'h32, "c_px02");
    read_px(8'd1, 9'd0, 8'h34, "c_px10");

    // Frame D: clear while a write is pending
    bus_if.start = 1'b1; cyc(); bus_if.start = 1'b0;
    vsync_pulse();
    bus_if.cam_href = 1'b1;
    bus_if.cam_valid = 1'b1; bus_if.cam_data = 8'h40; cyc();
    bus_if.cam_data = 8'h41; cyc();
    bus_if.cam_valid = 1'b0; cyc();
    bus_if.cam_valid = 1'b1; bus_if.cam_data = 8'h42; cyc();
    bus_if.cam_valid = 1'b0;
    chk("d_err_before", 32'(bus_if.err), 32'd1);
    chk("d_busy_before", 32'(bus_if.busy), 32'd1);
    clear = 1'b1; cyc(); clear = 1'b0;
    chk("d_clr_busy", 32'(bus_if.busy), 32'd0);
    chk("d_clr_we", 32'(bus_if.ram_we), 32'd0);
    chk("d_clr_ready", 32'(bus_if.frame_ready), 32'd0);
    chk("d_clr_err", 32'(bus_if.err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus_if.cam_valid = 1'b1; bus_if.cam_data = 8'h50 + 8'(i); cyc();
      bus_if.cam_valid = 1'b0; cyc();
    end
    bus_if.cam_href = 1'b0; cyc();
    chk("d_no_writes", 32'(wr_cnt), 32'd19);
    chk("d_idle_busy", 32'(bus_if.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
